i2c_bus_conditioner: RTL and testbench
======================================

// Module: i2c_bus_conditioner
// PURPOSE
//  Front-end stage between the raw I2C pad inputs and the i2c slave core.
//  - Synchronises SCL/SDA into the clk domain and deglitches each line.
//  - Delivers clean levels as i2c_port_t.
//  - Emits single-cycle SCL edge, START and STOP event pulses, plus a bus-busy flag.
//  - The slave FSM consumes these pulses and never samples the pads directly.
// PARAMETERS
//  SYNC_STAGES    2  flops per line in the synchroniser chain (>=2)
//  FILTER_CYCLES  4  consecutive cycles a new synced level must persist before it is accepted (>=1)
//  CNT_W          localparam = $clog2(FILTER_CYCLES+1); filter counter width
// PORTS
//  clk          in   1             system clock
//  rst          in   1             async reset, active-high
//  i_bus        in   i2c_port_t    raw pad levels {scl,sda}, asynchronous to clk
//  o_bus        out  i2c_port_t    synchronised + filtered levels
//  o_scl_rise   out  1             1-cycle pulse: filtered SCL 0->1
//  o_scl_fall   out  1             1-cycle pulse: filtered SCL 1->0
//  o_start      out  1             1-cycle pulse: START or repeated START detected
//  o_stop       out  1             1-cycle pulse: STOP detected
//  o_bus_busy   out  1             high between START and STOP
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - sync flops and o_bus = 1'b1 (idle-high bus); counters = 0.
//   - all pulses = 0; o_bus_busy = 0.
//  Synchroniser: SYNC_STAGES-deep shift chain per line; last stage = synced level.
//  Filter, per line, independent:
//   - synced == filtered: counter <= 0.
//   - synced != filtered and counter < FILTER_CYCLES-1: counter++.
//   - synced != filtered and counter == FILTER_CYCLES-1: filtered <= synced, counter <= 0.
//   - A mismatch shorter than FILTER_CYCLES cycles is discarded, with no output change.
//   - Latency from the first clk edge sampling a new raw level to o_bus change
//     = SYNC_STAGES + FILTER_CYCLES edges (6 at defaults).
//  Event pulses: registered; asserted in the same cycle o_bus first shows the new level.
//   - scl_rise / scl_fall: filtered SCL update 0->1 / 1->0.
//   - start: filtered SDA 1->0 while filtered SCL is 1 before and after the update.
//   - stop: filtered SDA 0->1 while filtered SCL is 1 before and after the update.
//   - SCL and SDA update in the same cycle: SCL change wins.
//     Only the scl_rise/scl_fall pulse fires; no start/stop.
//   - SDA change while SCL = 0: no event (normal data transition).
//  Busy flag:
//   - o_bus_busy <= 1 the cycle after o_start; <= 0 the cycle after o_stop.
//   - Repeated START while busy pulses o_start and keeps busy = 1.
//   - STOP while not busy pulses o_stop; busy stays 0.
//  Reset mid-transfer:
//   - All state returns to reset values immediately; no pulse is generated by reset.
//   - After release, a bus held low is tracked through the normal filter path:
//     pulses fire only once filtered levels change.
//  No combinational path from i_bus to any output.
// STRUCTURE
//  i2c_primitives_pkg (shared package):
//   - existing i2c_port_t;
//   - add localparam I2C_IDLE_LEVEL = 1'b1;
//   - add typedef struct {scl_rise, scl_fall, start, stop} i2c_bus_event_t
//     for use by the slave core.
//  Sub-module i2c_line_filter (params SYNC_STAGES, FILTER_CYCLES):
//   - contents: synchroniser + counter filter for one line.
//   - ports: clk, rst, i_line, o_level, o_update (1-cycle, asserted with the level change).
//   - instantiated twice (scl, sda).
//  Top: edge/START/STOP decode and busy register.
// TESTING (SYNC_STAGES=2, FILTER_CYCLES=4)
//  1 Reset, i_bus={0,0} held, rst pulsed -> o_bus={1,1}, pulses 0, busy 0 during reset;
//    o_scl_fall and no o_start 6 cycles after release.
//  2 SCL=1, SDA low for 3 cycles then high -> o_bus.sda stays 1, no o_start;
//    repeat with a 4-cycle low -> o_bus.sda low for 4 cycles, o_start then o_stop.
//  3 SCL=1, SDA 1->0 held -> o_bus.sda falls 6 edges after first sample, o_start for 1 cycle,
//    busy=1 next cycle; SDA 0->1 later -> o_stop 1 cycle, busy=0 next cycle.
//  4 SCL toggling with a 20-cycle period, SDA changing only while SCL=0 ->
//    exactly one o_scl_rise and one o_scl_fall per period, zero start/stop.
//  5 SCL and SDA both 1->0 on the same raw edge -> o_scl_fall only, no o_start, busy unchanged.
//  6 Repeated START while busy -> o_start pulses, busy stays 1; rst mid-byte -> busy=0 at once.

Source files
------------

// File: rtl/i2c_primitives_pkg.sv
// Shared I2C types for the pad front-end and the slave core.
package i2c_primitives_pkg;

    typedef struct packed {
        logic scl;
        logic sda;
    } i2c_port_t;

    localparam logic I2C_IDLE_LEVEL = 1'b1;

    typedef struct packed {
        logic scl_rise;
        logic scl_fall;
        logic start;
        logic stop;
    } i2c_bus_event_t;

endpackage

// File: rtl/i2c_line_filter.sv
// One I2C line: synchroniser chain followed by a persistence filter.
module i2c_line_filter
    import i2c_primitives_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level,
    output logic o_update
);

    localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   synced;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {SYNC_STAGES{I2C_IDLE_LEVEL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], i_line};
        end
    end

    assign synced = sync[SYNC_STAGES-1];

    // A new level must persist FILTER_CYCLES consecutive cycles; any return to
    // the accepted level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_level  <= I2C_IDLE_LEVEL;
            cnt      <= '0;
            o_update <= 1'b0;
        end else begin
            o_update <= 1'b0;
            if (synced == o_level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILTER_CYCLES - 1)) begin
                o_level  <= synced;
                cnt      <= '0;
                o_update <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_conditioner.sv
// Pad front-end: filtered SCL/SDA levels, edge/START/STOP pulses and busy flag.
module i2c_bus_conditioner
    import i2c_primitives_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  i2c_port_t i_bus,
    output i2c_port_t o_bus,
    output logic      o_scl_rise,
    output logic      o_scl_fall,
    output logic      o_start,
    output logic      o_stop,
    output logic      o_bus_busy
);

    logic           scl_lvl, scl_upd;
    logic           sda_lvl, sda_upd;
    i2c_bus_event_t evt;

    i2c_line_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_scl_filter (
        .clk      (clk),
        .rst      (rst),
        .i_line   (i_bus.scl),
        .o_level  (scl_lvl),
        .o_update (scl_upd)
    );

    i2c_line_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_sda_filter (
        .clk      (clk),
        .rst      (rst),
        .i_line   (i_bus.sda),
        .o_level  (sda_lvl),
        .o_update (sda_upd)
    );

    // Decoded purely from the filter flops, so pulses line up with the new
    // level on o_bus. An SCL update suppresses START/STOP in the same cycle.
    always_comb begin
        evt          = '0;
        evt.scl_rise = scl_upd & scl_lvl;
        evt.scl_fall = scl_upd & ~scl_lvl;
        evt.start    = sda_upd & ~sda_lvl & scl_lvl & ~scl_upd;
        evt.stop     = sda_upd & sda_lvl & scl_lvl & ~scl_upd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_bus_busy <= 1'b0;
        end else if (evt.start) begin
            o_bus_busy <= 1'b1;
        end else if (evt.stop) begin
            o_bus_busy <= 1'b0;
        end
    end

    always_comb begin
        o_bus.scl = scl_lvl;
        o_bus.sda = sda_lvl;
    end

    assign o_scl_rise = evt.scl_rise;
    assign o_scl_fall = evt.scl_fall;
    assign o_start    = evt.start;
    assign o_stop     = evt.stop;

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Scoreboard bench for i2c_bus_conditioner at SYNC_STAGES=2, FILTER_CYCLES=4.
module tb_i2c_bus_conditioner;
    import i2c_primitives_pkg::*;

    localparam int LAT = 6;
    localparam logic [3:0] EV_RISE  = 4'b1000;
    localparam logic [3:0] EV_FALL  = 4'b0100;
    localparam logic [3:0] EV_START = 4'b0010;
    localparam logic [3:0] EV_STOP  = 4'b0001;

    typedef struct {
        logic [3:0] ev;
        int         cyc;
    } exp_t;

    logic      clk = 1'b0;
    logic      rst;
    i2c_port_t i_bus;
    i2c_port_t o_bus;
    logic      o_scl_rise, o_scl_fall, o_start, o_stop, o_bus_busy;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q[$];

    i2c_bus_conditioner #(
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_bus      (i_bus),
        .o_bus      (o_bus),
        .o_scl_rise (o_scl_rise),
        .o_scl_fall (o_scl_fall),
        .o_start    (o_start),
        .o_stop     (o_stop),
        .o_bus_busy (o_bus_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_ev(input logic [3:0] ev, input int delay);
        exp_t e;
        e.ev  = ev;
        e.cyc = cyc + delay;
        q.push_back(e);
    endtask

    task automatic drive(input logic scl, input logic sda);
        i_bus.scl = scl;
        i_bus.sda = sda;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every observed pulse must match the oldest expectation, in kind and cycle.
    always @(posedge clk) begin : monitor
        logic [3:0] ev;
        exp_t       e;
        #1;
        ev = {o_scl_rise, o_scl_fall, o_start, o_stop};
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            check("missed_event", 32'(0), 32'(e.ev));
        end
        if (ev != 4'b0) begin
            if (q.size() == 0) begin
                check("spurious_event", 32'(ev), 32'(0));
            end else begin
                e = q.pop_front();
                check("event_kind", 32'(ev), 32'(e.ev));
                check("event_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with pads held low
        rst = 1'b1;
        drive(1'b0, 1'b0);
        wait_cyc(3);
        check("rst_bus", 32'(o_bus), 32'(2'b11));
        check("rst_pulses", 32'({o_scl_rise, o_scl_fall, o_start, o_stop}), 32'(0));
        check("rst_busy", 32'(o_bus_busy), 32'(0));
        rst = 1'b0;
        expect_ev(EV_FALL, LAT);
        wait_cyc(8);
        check("post_rst_bus", 32'(o_bus), 32'(2'b00));
        check("post_rst_busy", 32'(o_bus_busy), 32'(0));

        // STOP while idle: pulse only, busy stays low
        drive(1'b1, 1'b0);
        expect_ev(EV_RISE, LAT);
        wait_cyc(10);
        drive(1'b1, 1'b1);
        expect_ev(EV_STOP, LAT);
        wait_cyc(7);
        check("idle_stop_busy", 32'(o_bus_busy), 32'(0));
        wait_cyc(3);

        // 2: 3-cycle SDA glitch is rejected
        drive(1'b1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("glitch3_sda", 32'(o_bus.sda), 32'(1));
            if (i == 3) drive(1'b1, 1'b1);
        end

        // 2: 4-cycle SDA low is accepted: START then STOP
        drive(1'b1, 1'b0);
        expect_ev(EV_START, LAT);
        expect_ev(EV_STOP, LAT + 4);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("glitch4_sda", 32'(o_bus.sda), 32'((i >= 6 && i < 10) ? 0 : 1));
            check("glitch4_busy", 32'(o_bus_busy), 32'((i >= 7 && i < 11) ? 1 : 0));
            if (i == 4) drive(1'b1, 1'b1);
        end

        // 3: START held, later STOP
        drive(1'b1, 1'b0);
        expect_ev(EV_START, LAT);
        wait_cyc(5);
        check("start_sda_pre", 32'(o_bus.sda), 32'(1));
        wait_cyc(1);
        check("start_sda", 32'(o_bus.sda), 32'(0));
        wait_cyc(1);
        check("start_busy", 32'(o_bus_busy), 32'(1));
        wait_cyc(5);
        drive(1'b1, 1'b1);
        expect_ev(EV_STOP, LAT);
        wait_cyc(6);
        check("stop_busy_same", 32'(o_bus_busy), 32'(1));
        wait_cyc(1);
        check("stop_busy_next", 32'(o_bus_busy), 32'(0));
        wait_cyc(5);

        // 4: SCL clocking, SDA moves only while SCL low
        for (int p = 0; p < 3; p++) begin
            drive(1'b0, i_bus.sda);
            expect_ev(EV_FALL, LAT);
            wait_cyc(5);
            drive(1'b0, ~i_bus.sda);
            wait_cyc(5);
            drive(1'b1, i_bus.sda);
            expect_ev(EV_RISE, LAT);
            wait_cyc(10);
        end
        check("clocking_busy", 32'(o_bus_busy), 32'(0));

        // back to idle {1,1} via SCL low
        drive(1'b0, 1'b0);
        expect_ev(EV_FALL, LAT);
        wait_cyc(10);
        drive(1'b0, 1'b1);
        wait_cyc(10);
        drive(1'b1, 1'b1);
        expect_ev(EV_RISE, LAT);
        wait_cyc(10);

        // 5: SCL and SDA fall together -> SCL fall only
        drive(1'b0, 1'b0);
        expect_ev(EV_FALL, LAT);
        wait_cyc(7);
        check("both_fall_bus", 32'(o_bus), 32'(2'b00));
        check("both_fall_busy", 32'(o_bus_busy), 32'(0));
        wait_cyc(3);

        // 6: START, clock low, repeated START, then reset mid-byte
        drive(1'b0, 1'b1);
        wait_cyc(10);
        drive(1'b1, 1'b1);
        expect_ev(EV_RISE, LAT);
        wait_cyc(10);
        drive(1'b1, 1'b0);
        expect_ev(EV_START, LAT);
        wait_cyc(10);
        check("busy_first_start", 32'(o_bus_busy), 32'(1));
        drive(1'b0, 1'b0);
        expect_ev(EV_FALL, LAT);
        wait_cyc(10);
        drive(1'b0, 1'b1);
        wait_cyc(10);
        drive(1'b1, 1'b1);
        expect_ev(EV_RISE, LAT);
        wait_cyc(10);
        check("busy_before_rstart", 32'(o_bus_busy), 32'(1));
        drive(1'b1, 1'b0);
        expect_ev(EV_START, LAT);
        wait_cyc(7);
        check("busy_after_rstart", 32'(o_bus_busy), 32'(1));
        wait_cyc(3);
        drive(1'b0, 1'b0);
        wait_cyc(3);
        rst = 1'b1;
        q.delete();
        #1;
        check("midrst_busy", 32'(o_bus_busy), 32'(0));
        check("midrst_bus", 32'(o_bus), 32'(2'b11));
        check("midrst_pulses", 32'({o_scl_rise, o_scl_fall, o_start, o_stop}), 32'(0));
        wait_cyc(2);
        rst = 1'b0;
        expect_ev(EV_FALL, LAT);
        wait_cyc(10);
        check("after_midrst_bus", 32'(o_bus), 32'(2'b00));
        check("after_midrst_busy", 32'(o_bus_busy), 32'(0));

        wait_cyc(4);
        check("leftover_expect", 32'(q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
